// File: rtl/prism_cfg_loader.sv
// Configuration sequencer: streams (address, data) records into the PRISM debug
// write port while holding the PRISM FSM in debug reset; host writes always win.
module prism_cfg_loader #(
    parameter int RESET_CYCLES = 4,
    parameter int CNT_W        = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] rec_count,
    input  logic             auto_enable,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    input  logic [5:0]       host_addr,
    input  logic             host_wr,
    input  logic [31:0]      host_wdata,
    output logic [5:0]       dbg_addr,
    output logic             dbg_wr,
    output logic [31:0]      dbg_wdata,
    output logic             fsm_reset,
    output logic             fsm_enable,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [2:0]       state_dbg
);

    // Stream handshake: a byte transfers on a rising clk edge where in_valid & in_ready.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HOLD    = 3'd1,
        S_ADDR    = 3'd2,
        S_DATA    = 3'd3,
        S_WRITE   = 3'd4,
        S_RELEASE = 3'd5
    } state_t;

    localparam logic [3:0] HOLD_INIT = 4'(RESET_CYCLES);

    state_t           state_q, state_d;
    logic [3:0]       hold_q, hold_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             auto_en_q, auto_en_d;
    logic [5:0]       addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [1:0]       idx_q, idx_d;
    logic             fsm_reset_q, fsm_reset_d;
    logic             fsm_enable_q, fsm_enable_d;
    logic             err_q, err_d;
    logic             seq_wr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            hold_q       <= '0;
            rem_q        <= '0;
            auto_en_q    <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            idx_q        <= '0;
            fsm_reset_q  <= 1'b0;
            fsm_enable_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            rem_q        <= rem_d;
            auto_en_q    <= auto_en_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            idx_q        <= idx_d;
            fsm_reset_q  <= fsm_reset_d;
            fsm_enable_q <= fsm_enable_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        rem_d        = rem_q;
        auto_en_d    = auto_en_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        idx_d        = idx_q;
        fsm_reset_d  = fsm_reset_q;
        fsm_enable_d = fsm_enable_q;
        err_d        = err_q;
        in_ready     = 1'b0;
        seq_wr       = 1'b0;
        done         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d      = S_HOLD;
                    rem_d        = rec_count;
                    auto_en_d    = auto_enable;
                    err_d        = 1'b0;
                    hold_d       = HOLD_INIT;
                    fsm_reset_d  = 1'b1;
                    fsm_enable_d = 1'b0;
                end
            end
            S_HOLD: begin
                hold_d = hold_q - 4'd1;
                // Leaving on the cycle the count reaches zero gives RESET_CYCLES hold cycles.
                if (hold_q <= 4'd1) begin
                    hold_d = '0;
                    if (rem_q != '0) begin
                        state_d = S_ADDR;
                    end else begin
                        state_d      = S_RELEASE;
                        fsm_reset_d  = 1'b0;
                        fsm_enable_d = auto_en_q;
                    end
                end
            end
            S_ADDR: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (in_data[7:6] != 2'b00) begin
                        state_d      = S_IDLE;
                        err_d        = 1'b1;
                        fsm_reset_d  = 1'b0;
                        fsm_enable_d = 1'b0;
                    end else begin
                        addr_d  = in_data[5:0];
                        idx_d   = '0;
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    wdata_d[{idx_q, 3'b000} +: 8] = in_data;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (!host_wr) begin
                    seq_wr = 1'b1;
                    rem_d  = rem_q - CNT_W'(1);
                    if (rem_q != CNT_W'(1)) begin
                        state_d = S_ADDR;
                    end else begin
                        state_d      = S_RELEASE;
                        fsm_reset_d  = 1'b0;
                        fsm_enable_d = auto_en_q;
                    end
                end
            end
            S_RELEASE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Abort overrides every transition and discards any partial record.
        if (abort && state_q != S_IDLE) begin
            state_d      = S_IDLE;
            err_d        = 1'b1;
            fsm_reset_d  = 1'b0;
            fsm_enable_d = 1'b0;
            wdata_d      = '0;
            idx_d        = '0;
            in_ready     = 1'b0;
            seq_wr       = 1'b0;
            done         = 1'b0;
        end
    end

    assign dbg_wr     = host_wr | seq_wr;
    assign dbg_addr   = host_wr ? host_addr  : addr_q;
    assign dbg_wdata  = host_wr ? host_wdata : wdata_q;
    assign fsm_reset  = fsm_reset_q;
    assign fsm_enable = fsm_enable_q;
    assign err        = err_q;
    assign busy       = (state_q != S_IDLE);
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_prism_cfg_loader.sv
// Directed bench for prism_cfg_loader: record streaming, host priority, error,
// abort, full-range count, stalled stream and asynchronous reset.
module tb_prism_cfg_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [5:0]  rec_count = '0;
    logic        auto_enable = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_ready;
    logic [5:0]  host_addr = 6'h18;
    logic        host_wr = 1'b0;
    logic [31:0] host_wdata = 32'h7F;
    logic [5:0]  dbg_addr;
    logic        dbg_wr;
    logic [31:0] dbg_wdata;
    logic        fsm_reset, fsm_enable, busy, done, err;
    logic [2:0]  state_dbg;

    int checks = 0;
    int failures = 0;

    logic [7:0]  stim[$];
    logic [37:0] wr_log[$];
    logic        en_at_done, rst_at_done;
    int          host_bad, done_cnt;

    prism_cfg_loader #(.RESET_CYCLES(4), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .rec_count(rec_count), .auto_enable(auto_enable),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .host_addr(host_addr), .host_wr(host_wr), .host_wdata(host_wdata),
        .dbg_addr(dbg_addr), .dbg_wr(dbg_wr), .dbg_wdata(dbg_wdata),
        .fsm_reset(fsm_reset), .fsm_enable(fsm_enable), .busy(busy),
        .done(done), .err(err), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Inputs change at negedge; outputs are sampled 1ns later, well before posedge.
    task automatic start_load(input logic [5:0] n, input logic ae, input logic ab);
        @(negedge clk);
        rec_count = n; auto_enable = ae; start = 1'b1; abort = ab;
        in_valid = 1'b0; host_wr = 1'b0;
        wr_log.delete();
        #1;
    endtask

    // Cycle c=1 is the first cycle after the start edge.
    task automatic run_load(input int gap, input int host_at, input int abort_at,
                            input int max_cyc, output int done_at, output int end_at,
                            output int rst_low, output bit rdy_seen);
        done_at = -1; end_at = 0; rst_low = 0; rdy_seen = 0;
        host_bad = 0; done_cnt = 0; en_at_done = 1'b0; rst_at_done = 1'b1;
        for (int c = 1; c <= max_cyc; c++) begin
            @(negedge clk);
            start    = 1'b0;
            in_valid = (stim.size() > 0) && (gap <= 1 || (c % gap) == 0);
            in_data  = in_valid ? stim[0] : 8'h00;
            host_wr  = (c >= host_at && c < host_at + 3);
            abort    = (c == abort_at);
            #1;
            end_at = c;
            if (!busy) break;
            if (in_ready) rdy_seen = 1'b1;
            if (in_valid && in_ready) void'(stim.pop_front());
            if (host_wr && (dbg_wr !== 1'b1 || dbg_addr !== 6'h18 || dbg_wdata !== 32'h7F))
                host_bad++;
            if (dbg_wr && !host_wr) wr_log.push_back({dbg_addr, dbg_wdata});
            if (done) begin
                done_at = c; done_cnt++;
                en_at_done = fsm_enable; rst_at_done = fsm_reset;
            end else if (!fsm_reset) begin
                rst_low++;
            end
        end
        in_valid = 1'b0; host_wr = 1'b0; abort = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({in_ready, dbg_wr, dbg_addr, dbg_wdata, fsm_reset, fsm_enable, busy, done, err} !== 45'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %0h expected 0",
                     {in_ready, dbg_wr, dbg_addr, dbg_wdata, fsm_reset, fsm_enable, busy, done, err});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if ({busy, fsm_reset, err, state_dbg} !== 6'd0) begin
            failures++;
            $display("FAIL reset_release_idle: got %0h expected 0", {busy, fsm_reset, err, state_dbg});
        end
    endtask

    task automatic test_basic_load();
        int d, e, r; bit rs;
        stim = '{8'h05, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h06, 8'h01, 8'h00, 8'h00, 8'h00};
        start_load(6'd2, 1'b1, 1'b0);
        run_load(1, 1000, 0, 40, d, e, r, rs);
        checks++;
        if (wr_log.size() !== 2) begin
            failures++; $display("FAIL basic_wr_count: got %0d expected 2", wr_log.size());
        end else begin
            checks++;
            if (wr_log[0] !== {6'h05, 32'hDEADBEEF}) begin
                failures++; $display("FAIL basic_wr0: got %0h expected %0h", wr_log[0], {6'h05, 32'hDEADBEEF});
            end
            checks++;
            if (wr_log[1] !== {6'h06, 32'h00000001}) begin
                failures++; $display("FAIL basic_wr1: got %0h expected %0h", wr_log[1], {6'h06, 32'h00000001});
            end
        end
        checks++;
        if (d !== 17) begin failures++; $display("FAIL basic_latency: got %0d expected 17", d); end
        checks++;
        if (r !== 0) begin failures++; $display("FAIL basic_fsm_reset_low_cycles: got %0d expected 0", r); end
        checks++;
        if ({rst_at_done, en_at_done} !== 2'b01) begin
            failures++; $display("FAIL basic_release_outputs: got %0b expected 01", {rst_at_done, en_at_done});
        end
        checks++;
        if (done_cnt !== 1) begin failures++; $display("FAIL basic_done_pulses: got %0d expected 1", done_cnt); end
        checks++;
        if ({fsm_enable, done, busy} !== 3'b100) begin
            failures++; $display("FAIL basic_idle_after: got %0b expected 100", {fsm_enable, done, busy});
        end
    endtask

    task automatic test_host_priority();
        int d, e, r; bit rs;
        stim = '{8'h21, 8'h44, 8'h33, 8'h22, 8'h11};
        start_load(6'd1, 1'b0, 1'b0);
        run_load(1, 10, 0, 40, d, e, r, rs);
        checks++;
        if (host_bad !== 0) begin failures++; $display("FAIL host_mux_cycles: got %0d bad expected 0", host_bad); end
        checks++;
        if (wr_log.size() !== 1) begin
            failures++; $display("FAIL host_seq_wr_count: got %0d expected 1", wr_log.size());
        end else begin
            checks++;
            if (wr_log[0] !== {6'h21, 32'h11223344}) begin
                failures++; $display("FAIL host_seq_wr: got %0h expected %0h", wr_log[0], {6'h21, 32'h11223344});
            end
        end
        checks++;
        if (d !== 14) begin failures++; $display("FAIL host_latency: got %0d expected 14", d); end
        checks++;
        if (en_at_done !== 1'b0) begin failures++; $display("FAIL host_enable: got %0b expected 0", en_at_done); end
    endtask

    task automatic test_zero_count();
        int d, e, r; bit rs;
        stim = '{8'h01, 8'h02};
        start_load(6'd0, 1'b0, 1'b0);
        run_load(1, 1000, 0, 20, d, e, r, rs);
        checks++;
        if (rs !== 1'b0) begin failures++; $display("FAIL zero_in_ready: got %0b expected 0", rs); end
        checks++;
        if (d !== 5) begin failures++; $display("FAIL zero_latency: got %0d expected 5", d); end
        checks++;
        if ({en_at_done, fsm_enable} !== 2'b00) begin
            failures++; $display("FAIL zero_enable: got %0b expected 00", {en_at_done, fsm_enable});
        end
        checks++;
        if (stim.size() !== 2) begin failures++; $display("FAIL zero_bytes_left: got %0d expected 2", stim.size()); end
    endtask

    task automatic test_bad_addr();
        int d, e, r; bit rs;
        stim = '{8'h45, 8'h01, 8'h02, 8'h03, 8'h04};
        start_load(6'd1, 1'b1, 1'b0);
        run_load(1, 1000, 0, 30, d, e, r, rs);
        checks++;
        if (e !== 6) begin failures++; $display("FAIL bad_addr_idle_cycle: got %0d expected 6", e); end
        checks++;
        if ({err, fsm_reset, fsm_enable, busy} !== 4'b1000) begin
            failures++; $display("FAIL bad_addr_outputs: got %0b expected 1000", {err, fsm_reset, fsm_enable, busy});
        end
        checks++;
        if (wr_log.size() !== 0 || d !== -1) begin
            failures++; $display("FAIL bad_addr_no_write: got writes=%0d done_at=%0d expected 0 and -1", wr_log.size(), d);
        end
        stim.delete();
        start_load(6'd0, 1'b0, 1'b0);
        run_load(1, 1000, 0, 20, d, e, r, rs);
        checks++;
        if ({err, d} !== {1'b0, 32'sd5}) begin
            failures++; $display("FAIL bad_addr_restart: got err=%0b done_at=%0d expected 0 and 5", err, d);
        end
    endtask

    task automatic test_abort();
        int d, e, r; bit rs;
        stim = '{8'h07, 8'h11, 8'h22, 8'h33, 8'h44, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00};
        start_load(6'd2, 1'b1, 1'b0);
        run_load(1, 1000, 8, 30, d, e, r, rs);
        checks++;
        if (e !== 9) begin failures++; $display("FAIL abort_idle_cycle: got %0d expected 9", e); end
        checks++;
        if ({err, in_ready, fsm_enable, fsm_reset} !== 4'b1000) begin
            failures++; $display("FAIL abort_outputs: got %0b expected 1000", {err, in_ready, fsm_enable, fsm_reset});
        end
        checks++;
        if (wr_log.size() !== 0) begin failures++; $display("FAIL abort_no_write: got %0d expected 0", wr_log.size()); end
        // Fresh load; abort raised together with start must lose to start.
        stim = '{8'h09, 8'h78, 8'h56, 8'h34, 8'h12};
        start_load(6'd1, 1'b1, 1'b1);
        run_load(1, 1000, 0, 30, d, e, r, rs);
        checks++;
        if (wr_log.size() !== 1) begin
            failures++; $display("FAIL abort_fresh_count: got %0d expected 1", wr_log.size());
        end else begin
            checks++;
            if (wr_log[0] !== {6'h09, 32'h12345678}) begin
                failures++; $display("FAIL abort_fresh_wr: got %0h expected %0h", wr_log[0], {6'h09, 32'h12345678});
            end
        end
        checks++;
        if (d !== 11) begin failures++; $display("FAIL abort_fresh_latency: got %0d expected 11", d); end
        checks++;
        if ({err, en_at_done} !== 2'b01) begin
            failures++; $display("FAIL abort_fresh_flags: got %0b expected 01", {err, en_at_done});
        end
    endtask

    task automatic test_max_count();
        int d, e, r, bad; bit rs;
        logic [31:0] w;
        logic [5:0]  a;
        stim.delete();
        for (int i = 0; i < 63; i++) begin
            a = 6'(i);
            w = {8'hA5, 8'(i), ~8'(i), 8'(i + 3)};
            stim.push_back({2'b00, a});
            for (int k = 0; k < 4; k++) stim.push_back(w[8*k +: 8]);
        end
        start_load(6'd63, 1'b1, 1'b0);
        run_load(1, 100000, 0, 500, d, e, r, rs);
        checks++;
        if (wr_log.size() !== 63) begin failures++; $display("FAIL max_wr_count: got %0d expected 63", wr_log.size()); end
        bad = 0;
        for (int i = 0; i < wr_log.size() && i < 63; i++) begin
            a = 6'(i);
            w = {8'hA5, 8'(i), ~8'(i), 8'(i + 3)};
            if (wr_log[i] !== {a, w}) bad++;
        end
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL max_wr_values: got %0d wrong expected 0", bad); end
        checks++;
        if (d !== 383) begin failures++; $display("FAIL max_latency: got %0d expected 383", d); end
    endtask

    task automatic test_stall_and_reset();
        int d, e, r; bit rs;
        stim = '{8'h2A, 8'hEF, 8'hCD, 8'hAB, 8'h89};
        start_load(6'd1, 1'b1, 1'b0);
        run_load(3, 1000, 0, 60, d, e, r, rs);
        checks++;
        if (wr_log.size() !== 1) begin
            failures++; $display("FAIL stall_wr_count: got %0d expected 1", wr_log.size());
        end else begin
            checks++;
            if (wr_log[0] !== {6'h2A, 32'h89ABCDEF}) begin
                failures++; $display("FAIL stall_wr: got %0h expected %0h", wr_log[0], {6'h2A, 32'h89ABCDEF});
            end
        end
        checks++;
        if (d !== 20) begin failures++; $display("FAIL stall_latency: got %0d expected 20", d); end
        start_load(6'd3, 1'b1, 1'b0);
        @(negedge clk);
        start = 1'b0;
        #1;
        checks++;
        if ({busy, fsm_reset} !== 2'b11) begin
            failures++; $display("FAIL hold_before_reset: got %0b expected 11", {busy, fsm_reset});
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, dbg_wr, dbg_addr, dbg_wdata, fsm_reset, fsm_enable, busy, done, err, state_dbg} !== 48'd0) begin
            failures++;
            $display("FAIL async_reset_outputs: got %0h expected 0",
                     {in_ready, dbg_wr, dbg_addr, dbg_wdata, fsm_reset, fsm_enable, busy, done, err, state_dbg});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_host_priority();
        test_zero_count();
        test_bad_addr();
        test_abort();
        test_max_count();
        test_stall_and_reset();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prism_cfg_loader.md
Name: prism_cfg_loader

Overview:
- Autonomous configuration sequencer for the PRISM controller's 32-bit debug write port.
- Consumes a byte stream of (address, data) records and holds the FSM in debug reset while loading.
- Writes each record to the debug port, then optionally releases the FSM by asserting enable.
- Shares the debug write port with direct host writes; the host always has priority.

Parameters:
- RESET_CYCLES, 4: cycles fsm_reset is held before the first record write (range 1..15).
- CNT_W, 6: width of the record-count input.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle pulse; begins a load sequence when idle
- abort  input  1  single-cycle pulse; cancels an in-progress load
- rec_count  input  CNT_W  records to load; sampled on start
- auto_enable  input  1  sampled on start; 1 = assert fsm_enable after load
- in_valid  input  1  stream byte valid
- in_data  input  8  stream byte
- in_ready  output  1  stream byte accepted when in_valid & in_ready
- host_addr  input  6  host debug address
- host_wr  input  1  host 32-bit debug write strobe
- host_wdata  input  32  host write data
- dbg_addr  output  6  to PRISM debug_addr
- dbg_wr  output  1  to PRISM debug_wr
- dbg_wdata  output  32  to PRISM debug_wdata
- fsm_reset  output  1  to PRISM debug_reset
- fsm_enable  output  1  to PRISM fsm_enable
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse on successful completion
- err  output  1  sticky error flag; cleared by the next accepted start

Behaviour:
- Reset values: in_ready=0, dbg_wr=0, dbg_addr=0, dbg_wdata=0, fsm_reset=0, fsm_enable=0, busy=0, done=0, err=0. State resets to IDLE; all internal counters reset to 0.
- Debug port mux (combinational):
  - host_wr=1: dbg_* = host_*. The host write always wins.
  - Otherwise dbg_* is driven by the sequencer. dbg_wr is high only in WRITE with host_wr=0.
- State machine:
  - IDLE: start=1 latches rec_count and auto_enable, clears err, loads the hold counter with RESET_CYCLES, drives fsm_reset=1 and fsm_enable=0, then goes to HOLD. start is ignored in every other state.
  - HOLD: fsm_reset=1. Count down each cycle. Exit at 0: to ADDR if the latched count != 0, else to RELEASE.
  - ADDR: in_ready=1. On handshake:
    - in_data[7:6] != 00: set err and go to IDLE, with fsm_reset=0 and fsm_enable=0.
    - Otherwise latch in_data[5:0] as the address, clear the byte index, and go to DATA.
  - DATA: in_ready=1. Accept 4 bytes, little-endian; byte k goes to wdata[8k+7:8k]. After the 4th handshake, go to WRITE.
  - WRITE: in_ready=0, fsm_reset=1.
    - host_wr=1: stall and retry next cycle.
    - host_wr=0: dbg_wr=1 for exactly one cycle, decrement the remaining count, then go to ADDR if the remaining count is still nonzero, else RELEASE.
  - RELEASE: one cycle. fsm_reset=0, fsm_enable=latched auto_enable, done=1. Then IDLE.
- fsm_reset is registered: 1 throughout HOLD, ADDR, DATA and WRITE; 0 otherwise.
- fsm_enable is registered:
  - Cleared on an accepted start and on abort.
  - Set in RELEASE only if auto_enable was latched as 1.
  - Holds its value in IDLE.
- Stream: no byte is consumed outside ADDR/DATA. in_valid gaps stall indefinitely with no timeout.
- abort (any non-IDLE state, highest priority over all transitions):
  - Go to IDLE next cycle; set err=1.
  - fsm_reset=0 and fsm_enable=0; no dbg_wr issued in that cycle.
  - Partially assembled data is discarded.
  - abort in IDLE has no effect.
- Simultaneous start and abort in IDLE: start wins.
- Latency with rec_count=1, in_valid held high, no host traffic: start to done = RESET_CYCLES + 5 + 1 + 1 cycles (hold, 5 bytes, write, release).
- rec_count is a full-range unsigned count; a value of 2^CNT_W−1 loads that many records with no wrap.
- rst_n asserted mid-operation: everything returns to reset values asynchronously, including fsm_reset=0.

Test Plan:
- Basic load: start with rec_count=2, auto_enable=1; stream 05 EF BE AD DE 06 01 00 00 00.
  - Required: dbg_wr pulses with (05, DEADBEEF) then (06, 00000001).
  - fsm_reset high from the cycle after start until RELEASE; fsm_enable=1 and one done pulse after the load.
- Host priority: hold host_wr=1 (addr 18, data 7F) for 3 cycles while in WRITE.
  - Required: the dbg port shows host values for those 3 cycles.
  - The sequencer write is issued on the first cycle with host_wr=0, and is issued exactly once.
- Zero count: start with rec_count=0, auto_enable=0.
  - Required: in_ready never asserts; done after RESET_CYCLES+1 cycles; fsm_enable stays 0.
- Bad address byte: first byte 0x45.
  - Required: err=1, state returns to IDLE, no dbg_wr, fsm_reset=0.
  - A subsequent start clears err.
- Abort mid-DATA: abort after 2 data bytes.
  - Required: no dbg_wr, err=1, in_ready=0, fsm_enable=0.
  - A fresh start then loads correctly.
- Stalled stream and reset: toggle in_valid 1-in-3 cycles and confirm data is correct; assert rst_n low during HOLD.
  - Required: all outputs return immediately to reset values.
